// File: rtl/ram_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : ram_fill_engine
// Description : Memory fill engine. Writes a region of SDRAM/DDR3 with a zero,
//               constant, address or LFSR pattern. Uses a ready/stall
//               handshake, optional gaps between bursts, abort, done pulse.
//               Optional feature macro: RAM_FILL_LFSR_EN (builds the LFSR
//               used by mode 3; without it mode 3 writes zero data).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fill_engine #(
  parameter int AW    = 25,
  parameter int DW    = 16,
  parameter int CW    = 26,
  parameter int BURST = 8,
  parameter int GAP   = 0
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_count,
  input  logic [DW-1:0] fill_value,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] words_left,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic          mem_busy
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] din_n;
  logic          we_n, busy_n, done_n;
  logic [CW-1:0] left_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [1:0]    mode_q, mode_n;
  logic [DW-1:0] fill_q, fill_n;
  logic          accept;
  logic [31:0]   lfsr_seed;
  logic [31:0]   lfsr_adv;

  // The controller takes the word on any edge where we is up and it is not stalling
  assign accept = mem_we && !mem_busy;

  // Data word for a given mode; address and LFSR are sized to DW by zero-extend/truncate
  function automatic logic [DW-1:0] pattern(input logic [1:0]    m,
                                            input logic [AW-1:0] a,
                                            input logic [DW-1:0] f,
                                            input logic [31:0]   l);
    case (m)
      2'd1:    pattern = f;
      2'd2:    pattern = DW'(a);
      2'd3:    pattern = DW'({l, l});
      default: pattern = '0;
    endcase
  endfunction

`ifdef RAM_FILL_LFSR_EN
  logic [31:0] lfsr;
  logic [31:0] seed_raw;

  // Right-shift Galois step
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  generate
    if (DW >= 32) begin : g_seed_wide
      assign seed_raw = fill_value[31:0];
    end else begin : g_seed_narrow
      assign seed_raw = {{(32-DW){1'b0}}, fill_value};
    end
  endgenerate

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  assign lfsr_seed = (seed_raw == 32'h0) ? 32'h1 : seed_raw;
  assign lfsr_adv  = lfsr_step(lfsr);

  // LFSR loads on an accepted start and advances on every accepted write
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      lfsr <= 32'h1;
    end else if (state == ST_IDLE && start && !abort && word_count != '0) begin
      lfsr <= lfsr_seed;
    end else if (state == ST_WRITE && accept && !abort) begin
      lfsr <= lfsr_adv;
    end
  end
`else
  assign lfsr_seed = 32'h0;
  assign lfsr_adv  = 32'h0;
`endif

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
    din_n   = mem_din;
    we_n    = mem_we;
    busy_n  = busy;
    done_n  = 1'b0;
    left_n  = words_left;
    burst_n = burst_cnt;
    gap_n   = gap_cnt;
    mode_n  = mode_q;
    fill_n  = fill_q;
    if (abort) begin
      // a write taken on the abort edge still happened, so it is counted
      if (state == ST_WRITE && accept) left_n = words_left - CW'(1);
      state_n = ST_IDLE;
      we_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          we_n   = 1'b0;
          busy_n = 1'b0;
          if (start) begin
            if (word_count != '0) begin
              mode_n  = mode;
              fill_n  = fill_value;
              addr_n  = base_addr;
              left_n  = word_count;
              burst_n = '0;
              din_n   = pattern(mode, base_addr, fill_value, lfsr_seed);
              we_n    = 1'b1;
              busy_n  = 1'b1;
              state_n = ST_WRITE;
            end else begin
              done_n  = 1'b1;
              state_n = ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (accept) begin
            left_n = words_left - CW'(1);
            addr_n = mem_addr + AW'(1);
            din_n  = pattern(mode_q, addr_n, fill_q, lfsr_adv);
            if (words_left == CW'(1)) begin
              state_n = ST_DONE;
              we_n    = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else if (GAP > 0 && burst_cnt == BURST_LAST) begin
              state_n = ST_GAP;
              we_n    = 1'b0;
              burst_n = '0;
              gap_n   = '0;
            end else begin
              burst_n = burst_cnt + BW'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state_n = ST_WRITE;
            we_n    = 1'b1;
          end else begin
            gap_n = gap_cnt + GW'(1);
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Registered outputs and working counters
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_left <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      mode_q     <= 2'd0;
      fill_q     <= '0;
    end else begin
      mem_addr   <= addr_n;
      mem_din    <= din_n;
      mem_we     <= we_n;
      busy       <= busy_n;
      done       <= done_n;
      words_left <= left_n;
      burst_cnt  <= burst_n;
      gap_cnt    <= gap_n;
      mode_q     <= mode_n;
      fill_q     <= fill_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fill_engine
// Description : Scoreboard bench for ram_fill_engine. Stimulus pushes the
//               expected writes and done pulses; a monitor pops and compares
//               on every accepted write. Honours RAM_FILL_LFSR_EN for mode 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fill_engine;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int CW    = 9;
  localparam int BURST = 4;
  localparam int GAP   = 2;

  logic          clk_sys = 1'b0;
  logic          RESET;
  logic          start, abort, mem_busy;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic [DW-1:0] fill_value;
  logic          busy, done, mem_we;
  logic [CW-1:0] words_left;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int  exp_done = 0;
  int  checks   = 0;
  int  errors   = 0;
  logic [9:0]  we_pat;
  logic [15:0] lfsr_d0, lfsr_d1;

  always #5 clk_sys = ~clk_sys;

  ram_fill_engine #(.AW(AW), .DW(DW), .CW(CW), .BURST(BURST), .GAP(GAP)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .word_count(word_count), .fill_value(fill_value),
    .busy(busy), .done(done), .words_left(words_left), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_busy(mem_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // One-cycle start pulse; returns in the cycle the first write is presented
  task automatic issue(input logic [1:0] m, input logic [AW-1:0] b,
                       input logic [CW-1:0] c, input logic [DW-1:0] f);
    mode = m; base_addr = b; word_count = c; fill_value = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Monitor: every accepted write must match the head of the scoreboard
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1 && mem_busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected none", mem_addr, mem_din);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
        chk("wr_data", 32'(mem_din), 32'(mon_w.data));
      end
    end
    if (done === 1'b1) begin
      if (exp_done == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        exp_done--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; start = 1'b0; abort = 1'b0; mem_busy = 1'b0;
    mode = 2'd0; base_addr = '0; word_count = '0; fill_value = '0;
`ifdef RAM_FILL_LFSR_EN
    lfsr_d0 = 16'h0001; lfsr_d1 = 16'h0003;
`else
    lfsr_d0 = 16'h0000; lfsr_d1 = 16'h0000;
`endif
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_left", 32'(words_left), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_we", 32'(mem_we), 0);
    RESET = 1'b1;
    tick();

    // zero fill: four consecutive writes, done one cycle after the last
    for (int i = 0; i < 4; i++) push_wr(AW'(8'h10 + i), 16'h0000);
    exp_done++;
    issue(2'd0, 8'h10, 9'd4, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("zf_we", 32'(mem_we), 1);
      chk("zf_addr", 32'(mem_addr), 32'h10 + i);
      chk("zf_busy", 32'(busy), 1);
      tick();
    end
    chk("zf_done", 32'(done), 1);
    chk("zf_we_off", 32'(mem_we), 0);
    chk("zf_busy_off", 32'(busy), 0);
    tick();
    chk("zf_done_pulse", 32'(done), 0);

    // stall: second word held for three busy cycles
    for (int i = 0; i < 3; i++) push_wr(AW'(8'h20 + i), 16'hA5A5);
    exp_done++;
    issue(2'd1, 8'h20, 9'd3, 16'hA5A5);
    chk("st_left3", 32'(words_left), 3);
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("st_hold_addr", 32'(mem_addr), 32'h21);
      chk("st_hold_data", 32'(mem_din), 32'hA5A5);
      chk("st_hold_we", 32'(mem_we), 1);
      tick();
    end
    mem_busy = 1'b0;
    chk("st_resume_addr", 32'(mem_addr), 32'h21);
    chk("st_left2", 32'(words_left), 2);
    tick();
    chk("st_addr3", 32'(mem_addr), 32'h22);
    chk("st_left1", 32'(words_left), 1);
    tick();
    chk("st_done", 32'(done), 1);
    chk("st_left0", 32'(words_left), 0);
    tick();

    // burst gap: 4 writes, 2 idle, 4 writes, done at cycle 12 from start
    for (int i = 0; i < 8; i++) push_wr(AW'(8'h40 + i), DW'(16'h0040 + i));
    exp_done++;
    we_pat = 10'b1111001111;
    issue(2'd2, 8'h40, 9'd8, 16'h0);
    for (int i = 0; i < 10; i++) begin
      chk("bg_we", 32'(mem_we), 32'(we_pat[9-i]));
      tick();
    end
    chk("bg_done", 32'(done), 1);
    tick();

    // address pattern wrapping past the top of an 8-bit address space
    push_wr(8'hFE, 16'h00FE);
    push_wr(8'hFF, 16'h00FF);
    push_wr(8'h00, 16'h0000);
    push_wr(8'h01, 16'h0001);
    exp_done++;
    issue(2'd2, 8'hFE, 9'd4, 16'h0);
    wait_done("wrap_done", 10);
    tick();

    // LFSR: seed 1 and seed 0 give the same sequence
    for (int s = 0; s < 2; s++) begin
      push_wr(8'h50, lfsr_d0);
      push_wr(8'h51, lfsr_d1);
      exp_done++;
      issue(2'd3, 8'h50, 9'd2, (s == 0) ? 16'h0001 : 16'h0000);
      wait_done("lfsr_done", 10);
      tick();
    end

    // abort on a stalled third write: two words performed
    push_wr(8'h60, 16'h1234);
    push_wr(8'h61, 16'h1234);
    issue(2'd1, 8'h60, 9'd10, 16'h1234);
    tick();
    tick();
    chk("ab_addr3", 32'(mem_addr), 32'h62);
    mem_busy = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mem_busy = 1'b0;
    chk("ab_we", 32'(mem_we), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_left", 32'(words_left), 8);
    tick();
    chk("ab_idle_we", 32'(mem_we), 0);

    // abort coinciding with an accepted write counts that write
    push_wr(8'h70, 16'h0);
    push_wr(8'h71, 16'h0);
    issue(2'd0, 8'h70, 9'd10, 16'h0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("aba_left", 32'(words_left), 8);
    chk("aba_we", 32'(mem_we), 0);

    // abort wins over start in IDLE
    abort = 1'b1;
    issue(2'd1, 8'h80, 9'd5, 16'h5555);
    abort = 1'b0;
    chk("abs_busy", 32'(busy), 0);
    chk("abs_we", 32'(mem_we), 0);
    tick();
    chk("abs_we2", 32'(mem_we), 0);

    // zero count: done pulse, no writes, busy stays low
    exp_done++;
    issue(2'd0, 8'h90, 9'd0, 16'h0);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_we", 32'(mem_we), 0);
    tick();
    chk("z_done_off", 32'(done), 0);

    // reset mid-fill clears all outputs on the next edge
    push_wr(8'h30, 16'hFFFF);
    push_wr(8'h31, 16'hFFFF);
    issue(2'd1, 8'h30, 9'd8, 16'hFFFF);
    tick();
    RESET = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_left", 32'(words_left), 0);
    chk("mr_addr", 32'(mem_addr), 0);
    chk("mr_din", 32'(mem_din), 0);
    chk("mr_we", 32'(mem_we), 0);
    RESET = 1'b1;
    tick();
    tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("done_balance", 32'(exp_done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
